// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage types and instruction field constants
package mips_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_KILL = 2'd1,
    S_FULL = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned PC_STEP   = 4;

  // Field positions used by both fetch and the control unit
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction memory request/ready bus
interface if_stage_if #(
  parameter int XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with flush/load/bubble/hold priority
module if_id_reg
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            advance_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc4_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc4_o
);

  logic            valid_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc4_q;

  // An invalid entry always carries a NOP so control decodes nothing live
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= XLEN'(NOP_INSTR);
      pc4_q   <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      instr_q <= XLEN'(NOP_INSTR);
    end else if (advance_i) begin
      if (load_i) begin
        valid_q <= 1'b1;
        instr_q <= instr_i;
        pc4_q   <= pc4_i;
      end else begin
        valid_q <= 1'b0;
        instr_q <= XLEN'(NOP_INSTR);
      end
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction fetch: PC, imem handshake FSM, skid buffer, IF/ID
module if_stage
  import mips_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst,
  if_stage_if.master      imem,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc4,
  output logic [5:0]      op_code,
  output logic [5:0]      funct_field
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc4_q, skid_pc4_d;

  logic            advance;
  logic            new_data;
  logic [XLEN-1:0] new_instr;
  logic [XLEN-1:0] new_pc4;
  logic [XLEN-1:0] pc_plus4;

  assign advance  = !if_id_valid || !stall;
  assign pc_plus4 = pc_q + XLEN'(PC_STEP);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    tgt_d        = tgt_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    new_data     = 1'b0;
    new_instr    = imem.imem_rdata;
    new_pc4      = pc_plus4;

    unique case (state_q)
      S_REQ: begin
        if (imem.imem_ready) begin
          if (redirect) begin
            pc_d       = redirect_pc;
            req_addr_d = redirect_pc;
          end else if (advance) begin
            new_data   = 1'b1;
            pc_d       = pc_plus4;
            req_addr_d = pc_plus4;
          end else begin
            skid_instr_d = imem.imem_rdata;
            skid_pc4_d   = pc_plus4;
            pc_d         = pc_plus4;
            state_d      = S_FULL;
          end
        end else if (redirect) begin
          tgt_d   = redirect_pc;
          state_d = S_KILL;
        end
      end

      // The in-flight request must complete at its original address before refetch
      S_KILL: begin
        if (redirect) begin
          tgt_d = redirect_pc;
        end
        if (imem.imem_ready) begin
          pc_d       = redirect ? redirect_pc : tgt_q;
          req_addr_d = redirect ? redirect_pc : tgt_q;
          state_d    = S_REQ;
        end
      end

      S_FULL: begin
        new_instr = skid_instr_q;
        new_pc4   = skid_pc4_q;
        if (redirect) begin
          pc_d       = redirect_pc;
          req_addr_d = redirect_pc;
          state_d    = S_REQ;
        end else if (advance) begin
          new_data   = 1'b1;
          req_addr_d = pc_q;
          state_d    = S_REQ;
        end
      end

      default: begin
        state_d    = S_REQ;
        req_addr_d = pc_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= PC_RESET;
      req_addr_q   <= PC_RESET;
      tgt_q        <= PC_RESET;
      skid_instr_q <= XLEN'(NOP_INSTR);
      skid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      tgt_q        <= tgt_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  // Request is withdrawn immediately under reset, not a cycle later
  assign imem.imem_req  = !rst && (state_q != S_FULL);
  assign imem.imem_addr = req_addr_q;

  if_id_reg #(
    .XLEN (XLEN)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (redirect),
    .advance_i (advance),
    .load_i    (new_data),
    .instr_i   (new_instr),
    .pc4_i     (new_pc4),
    .valid_o   (if_id_valid),
    .instr_o   (if_id_instr),
    .pc4_o     (if_id_pc4)
  );

  assign op_code     = if_id_instr[OPCODE_MSB:OPCODE_LSB];
  assign funct_field = if_id_instr[FUNCT_MSB:FUNCT_LSB];

endmodule
